// File: rtl/aes_ecb_axil_regs.sv
// AXI4-Lite register front end for the AES-ECB peripheral.
// Holds the 128-bit key and plaintext, pulses start to the core,
// and captures the ciphertext when the core signals done.
module aes_ecb_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic [127:0]                      aes_key,
  output logic [127:0]                      aes_pt,
  output logic                              aes_start,
  input  logic                              aes_done,
  input  logic [127:0]                      aes_ct
);

  localparam logic       W_IDLE      = 1'b0;
  localparam logic       W_RESP      = 1'b1;
  localparam logic       R_IDLE      = 1'b0;
  localparam logic       R_DATA      = 1'b1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic             w_state_r, r_state_r;
  logic             awready_r, wready_r, bvalid_r;
  logic [1:0]       bresp_r;
  logic             arready_r, rvalid_r;
  logic [1:0]       rresp_r;
  logic [31:0]      rdata_r;
  logic [3:0][31:0] key_r, pt_r;
  logic [127:0]     ct_r;
  logic             busy_r, done_r, start_r;

  logic             wr_accept_s, rd_accept_s;
  logic [3:0]       wr_idx_s, rd_idx_s;
  logic             wr_key_s, wr_pt_s, wr_ctrl_s, wr_ok_s, start_req_s;
  logic [31:0]      rd_data_s;
  logic [1:0]       rd_resp_s;
  logic             unused_s;

  // Merge the enabled byte lanes of new data into an existing word.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_v[8*i +: 8];
      end
    end
    return res;
  endfunction

  assign unused_s = ^{s00_axi_awprot, s00_axi_arprot,
                      s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // Write address decode: key/pt are writable only while the core is idle.
  always_comb begin
    wr_idx_s    = s00_axi_awaddr[5:2];
    wr_accept_s = awready_r & wready_r & s00_axi_awvalid & s00_axi_wvalid;
    wr_key_s    = 1'b0;
    wr_pt_s     = 1'b0;
    wr_ctrl_s   = 1'b0;
    case (wr_idx_s[3:2])
      2'b00:   wr_key_s  = ~busy_r;
      2'b01:   wr_pt_s   = ~busy_r;
      2'b10:   wr_ctrl_s = (wr_idx_s[1:0] == 2'b00);
      default: wr_ctrl_s = 1'b0;
    endcase
    wr_ok_s     = wr_key_s | wr_pt_s | wr_ctrl_s;
    start_req_s = wr_accept_s & wr_ctrl_s & s00_axi_wdata[0] &
                  s00_axi_wstrb[0] & ~busy_r;
  end

  // Write channel: accept AW and W together, then hold B until bready.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      w_state_r <= W_IDLE;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
    end else begin
      case (w_state_r)
        W_IDLE: begin
          if (wr_accept_s) begin
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b1;
            bresp_r   <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
            w_state_r <= W_RESP;
          end else if (s00_axi_awvalid && s00_axi_wvalid) begin
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
          end else begin
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
          end
        end
        W_RESP: begin
          if (s00_axi_bready) begin
            bvalid_r  <= 1'b0;
            w_state_r <= W_IDLE;
          end
        end
        default: w_state_r <= W_IDLE;
      endcase
    end
  end

  // Key and plaintext storage with byte-lane write enables.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      key_r <= 128'h0;
      pt_r  <= 128'h0;
    end else if (wr_accept_s && wr_key_s) begin
      key_r[wr_idx_s[1:0]] <= apply_strb(key_r[wr_idx_s[1:0]], s00_axi_wdata, s00_axi_wstrb);
    end else if (wr_accept_s && wr_pt_s) begin
      pt_r[wr_idx_s[1:0]] <= apply_strb(pt_r[wr_idx_s[1:0]], s00_axi_wdata, s00_axi_wstrb);
    end
  end

  // Core handshake: start pulse, busy/done flags, ciphertext capture.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      start_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ct_r    <= 128'h0;
    end else begin
      start_r <= start_req_s;
      if (start_req_s) begin
        busy_r <= 1'b1;
        done_r <= 1'b0;
      end else if (aes_done && busy_r) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
        ct_r   <= aes_ct;
      end
    end
  end

  // Read data mux; unmapped words answer SLVERR with zero data.
  always_comb begin
    rd_idx_s    = s00_axi_araddr[5:2];
    rd_accept_s = arready_r & s00_axi_arvalid;
    rd_resp_s   = RESP_OKAY;
    rd_data_s   = 32'h0;
    case (rd_idx_s)
      4'd0, 4'd1, 4'd2, 4'd3: rd_data_s = key_r[rd_idx_s[1:0]];
      4'd4, 4'd5, 4'd6, 4'd7: rd_data_s = pt_r[rd_idx_s[1:0]];
      4'd8:    rd_data_s = 32'h0;
      4'd9:    rd_data_s = {30'h0, done_r, busy_r};
      4'd10:   rd_data_s = ct_r[127:96];
      4'd11:   rd_data_s = ct_r[95:64];
      4'd12:   rd_data_s = ct_r[63:32];
      4'd13:   rd_data_s = ct_r[31:0];
      default: begin
        rd_resp_s = RESP_SLVERR;
        rd_data_s = 32'h0;
      end
    endcase
  end

  // Read channel: one-cycle arready, registered data held until rready.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rresp_r   <= RESP_OKAY;
      rdata_r   <= 32'h0;
    end else begin
      case (r_state_r)
        R_IDLE: begin
          if (rd_accept_s) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b1;
            rdata_r   <= rd_data_s;
            rresp_r   <= rd_resp_s;
            r_state_r <= R_DATA;
          end else if (s00_axi_arvalid) begin
            arready_r <= 1'b1;
          end else begin
            arready_r <= 1'b0;
          end
        end
        R_DATA: begin
          if (s00_axi_rready) begin
            rvalid_r  <= 1'b0;
            r_state_r <= R_IDLE;
          end
        end
        default: r_state_r <= R_IDLE;
      endcase
    end
  end

  assign s00_axi_awready = awready_r;
  assign s00_axi_wready  = wready_r;
  assign s00_axi_bvalid  = bvalid_r;
  assign s00_axi_bresp   = bresp_r;
  assign s00_axi_arready = arready_r;
  assign s00_axi_rvalid  = rvalid_r;
  assign s00_axi_rresp   = rresp_r;
  assign s00_axi_rdata   = rdata_r;
  assign aes_key         = {key_r[0], key_r[1], key_r[2], key_r[3]};
  assign aes_pt          = {pt_r[0], pt_r[1], pt_r[2], pt_r[3]};
  assign aes_start       = start_r;

endmodule

// File: tb/tb_aes_ecb_axil_regs.sv
// Self-checking bench for aes_ecb_axil_regs: table-driven register
// accesses plus hand sequences for the AES start/done and AXI corners.
module tb_aes_ecb_axil_regs;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic         clk;
  logic         areset;
  logic [5:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [127:0] aes_key, aes_pt, aes_ct;
  logic         aes_start, aes_done;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  logic [33:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;
  vec_t tbl[$];

  aes_ecb_axil_regs dut (
    .s00_axi_aclk(clk),       .s00_axi_areset(areset),
    .s00_axi_awaddr(awaddr),  .s00_axi_awprot(awprot),
    .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata),    .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid),  .s00_axi_wready(wready),
    .s00_axi_bresp(bresp),    .s00_axi_bvalid(bvalid),
    .s00_axi_bready(bready),  .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot),  .s00_axi_arvalid(arvalid),
    .s00_axi_arready(arready), .s00_axi_rdata(rdata),
    .s00_axi_rresp(rresp),    .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready),  .aes_key(aes_key),
    .aes_pt(aes_pt),          .aes_start(aes_start),
    .aes_done(aes_done),      .aes_ct(aes_ct)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count start pulses, one per high clock cycle.
  always @(posedge clk) begin
    if (aes_start) start_cnt <= start_cnt + 1;
  end

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [5:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [1:0] r, input logic [31:0] rd);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.strb = s; v.resp = r; v.rdata = rd;
    return v;
  endfunction

  task automatic do_reset();
    areset = 1'b1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arvalid = 1'b0; rready = 1'b0; aes_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 areset = 1'b0;
  endtask

  // Complete a write whose AW/W valids are already driven.
  task automatic wr_finish(input logic [5:0] a, input logic [1:0] er);
    int n;
    n = 0;
    while (!(awready && wready) && n < 20) begin @(posedge clk); #1; n++; end
    chk($sformatf("wr_ready@%02h", a), 128'(awready && wready), 128'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
    chk($sformatf("bresp@%02h", a), 128'({bvalid, bresp}), 128'({1'b1, er}));
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] er);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    wr_finish(a, er);
  endtask

  // Read with scoreboard; optionally pulse aes_done in the AR handshake cycle.
  task automatic axi_read(input logic [5:0] a, input logic [31:0] ed, input logic [1:0] er,
                          input logic pulse, input logic [127:0] ct);
    int n;
    logic [33:0] e;
    exp_q.push_back({ed, er});
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(posedge clk); #1; n++; end
    chk($sformatf("arready@%02h", a), 128'(arready), 128'd1);
    if (pulse) begin aes_ct = ct; aes_done = 1'b1; end
    @(posedge clk); #1;
    arvalid = 1'b0; aes_done = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
    e = exp_q.pop_front();
    chk($sformatf("rvalid@%02h", a), 128'(rvalid), 128'd1);
    chk($sformatf("rdata@%02h", a), 128'(rdata), 128'(e[33:2]));
    chk($sformatf("rresp@%02h", a), 128'(rresp), 128'(e[1:0]));
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic pulse_done(input logic [127:0] ct);
    aes_ct = ct; aes_done = 1'b1;
    @(posedge clk); #1;
    aes_done = 1'b0;
  endtask

  initial begin
    int s0;
    logic [127:0] fips_ct;
    logic [127:0] ct2;
    int n;
    fips_ct = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
    ct2     = 128'h11111111_22222222_33333333_44444444;
    awaddr = 6'h0; araddr = 6'h0; awprot = 3'h0; arprot = 3'h0;
    wdata = 32'h0; wstrb = 4'h0; aes_ct = 128'h0;
    do_reset();

    // Reset state of every output.
    chk("rst_hs", 128'({awready, wready, bvalid, arready, rvalid, aes_start}), 128'd0);
    chk("rst_resp", 128'({bresp, rresp, rdata}), 128'd0);
    chk("rst_key_pt", {aes_key ^ aes_pt} | aes_key, 128'd0);

    // Table: reset readback, then KEY0-3 write and readback.
    for (int a = 0; a < 16; a++)
      tbl.push_back(mk(1'b0, 6'(a * 4), 32'h0, 4'h0, (a >= 14) ? SLVERR : OKAY, 32'h0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1'b1, 6'(i * 4), 32'(i + 1), 4'hF, OKAY, 32'h0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1'b0, 6'(i * 4), 32'h0, 4'h0, OKAY, 32'(i + 1)));
    foreach (tbl[i]) begin
      if (tbl[i].wr) axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].resp);
      else           axi_read(tbl[i].addr, tbl[i].rdata, tbl[i].resp, 1'b0, 128'h0);
    end
    chk("aes_key_1234", aes_key, 128'h00000001_00000002_00000003_00000004);

    // Byte strobes after reset.
    do_reset();
    axi_write(6'h00, 32'hFFFFFFFF, 4'b0101, OKAY);
    axi_read(6'h00, 32'h00FF00FF, OKAY, 1'b0, 128'h0);

    // FIPS-197 load and start.
    axi_write(6'h00, 32'h00010203, 4'hF, OKAY);
    axi_write(6'h04, 32'h04050607, 4'hF, OKAY);
    axi_write(6'h08, 32'h08090a0b, 4'hF, OKAY);
    axi_write(6'h0C, 32'h0c0d0e0f, 4'hF, OKAY);
    axi_write(6'h10, 32'h00112233, 4'hF, OKAY);
    axi_write(6'h14, 32'h44556677, 4'hF, OKAY);
    axi_write(6'h18, 32'h8899aabb, 4'hF, OKAY);
    axi_write(6'h1C, 32'hccddeeff, 4'hF, OKAY);
    chk("fips_key", aes_key, 128'h000102030405060708090a0b0c0d0e0f);
    chk("fips_pt", aes_pt, 128'h00112233445566778899aabbccddeeff);
    s0 = start_cnt;
    axi_write(6'h20, 32'h1, 4'h1, OKAY);
    chk("start_once", 128'(start_cnt - s0), 128'd1);
    chk("start_low", 128'(aes_start), 128'd0);
    axi_read(6'h24, 32'h1, OKAY, 1'b0, 128'h0);
    axi_read(6'h20, 32'h0, OKAY, 1'b0, 128'h0);

    // Writes while busy.
    axi_write(6'h10, 32'hDEADBEEF, 4'hF, SLVERR);
    axi_read(6'h10, 32'h00112233, OKAY, 1'b0, 128'h0);
    axi_write(6'h00, 32'hDEADBEEF, 4'hF, SLVERR);
    chk("busy_key_stable", aes_key, 128'h000102030405060708090a0b0c0d0e0f);
    axi_write(6'h20, 32'h1, 4'h1, OKAY);
    chk("busy_no_restart", 128'(start_cnt - s0), 128'd1);
    axi_write(6'h2C, 32'h12345678, 4'hF, SLVERR);
    axi_read(6'h24, 32'h1, OKAY, 1'b0, 128'h0);

    // Completion.
    pulse_done(fips_ct);
    axi_read(6'h24, 32'h2, OKAY, 1'b0, 128'h0);
    axi_read(6'h28, 32'h69c4e0d8, OKAY, 1'b0, 128'h0);
    axi_read(6'h2C, 32'h6a7b0430, OKAY, 1'b0, 128'h0);
    axi_read(6'h30, 32'hd8cdb780, OKAY, 1'b0, 128'h0);
    axi_read(6'h34, 32'h70b4c55a, OKAY, 1'b0, 128'h0);

    // Second op: done clears on start; read coincident with done sees old value.
    axi_write(6'h20, 32'h1, 4'h1, OKAY);
    chk("start_twice", 128'(start_cnt - s0), 128'd2);
    axi_read(6'h24, 32'h1, OKAY, 1'b1, ct2);
    axi_read(6'h24, 32'h2, OKAY, 1'b0, 128'h0);
    axi_read(6'h28, 32'h11111111, OKAY, 1'b0, 128'h0);
    pulse_done(128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF);
    axi_read(6'h34, 32'h44444444, OKAY, 1'b0, 128'h0);

    // Handshake stress: AW early, bready withheld, second write queued.
    awaddr = 6'h04; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("aw_alone_wait", 128'({awready, wready}), 128'd0);
    end
    wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 20) begin @(posedge clk); #1; n++; end
    chk("stress_accept", 128'(awready && wready), 128'd1);
    @(posedge clk); #1;
    awaddr = 6'h08; wdata = 32'h5A5A5A5A;
    for (int i = 0; i < 5; i++) begin
      chk("b_hold", 128'({awready, wready, bvalid, bresp}), 128'(5'b00100));
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("b_done", 128'(bvalid), 128'd0);
    wr_finish(6'h08, OKAY);
    axi_read(6'h04, 32'hA5A5A5A5, OKAY, 1'b0, 128'h0);
    axi_read(6'h08, 32'h5A5A5A5A, OKAY, 1'b0, 128'h0);

    // Reset while busy with a read response in flight.
    axi_write(6'h20, 32'h1, 4'h1, OKAY);
    araddr = 6'h24; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
    arvalid = 1'b0;
    chk("inflight_rvalid", 128'(rvalid), 128'd1);
    areset = 1'b1;
    #1;
    chk("rst_drop_r", 128'({rvalid, bvalid, aes_start}), 128'd0);
    chk("rst_pt", aes_pt, 128'd0);
    do_reset();
    axi_read(6'h24, 32'h0, OKAY, 1'b0, 128'h0);
    pulse_done(fips_ct);
    for (int i = 0; i < 4; i++)
      axi_read(6'(8'h28 + 4 * i), 32'h0, OKAY, 1'b0, 128'h0);
    axi_read(6'h24, 32'h0, OKAY, 1'b0, 128'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/aes_ecb_axil_regs.md
Name: aes_ecb_axil_regs

Overview:
AXI4-Lite slave register front end for the AES-ECB peripheral. It sits directly downstream of the AXI4-Lite master (VIP/BFM or PS interconnect). It stores the 128-bit key and plaintext, issues a start pulse to the AES core and captures the ciphertext when the core reports done. All transfers are single-beat, with at most one outstanding write and one outstanding read.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width (only 32 supported)
C_S_AXI_ADDR_WIDTH, 6, byte address width (register map spans 0x00-0x3C)

Ports:
s00_axi_aclk  in  1  clock
s00_axi_areset  in  1  asynchronous, active-high reset
s00_axi_awaddr  in  6  write address
s00_axi_awprot  in  3  ignored
s00_axi_awvalid / s00_axi_awready  in/out  1  AW handshake
s00_axi_wdata  in  32  write data
s00_axi_wstrb  in  4  byte enables
s00_axi_wvalid / s00_axi_wready  in/out  1  W handshake
s00_axi_bresp  out  2  write response
s00_axi_bvalid / s00_axi_bready  out/in  1  B handshake
s00_axi_araddr  in  6  read address
s00_axi_arprot  in  3  ignored
s00_axi_arvalid / s00_axi_arready  in/out  1  AR handshake
s00_axi_rdata  out  32  read data
s00_axi_rresp  out  2  read response
s00_axi_rvalid / s00_axi_rready  out/in  1  R handshake
aes_key  out  128  key; word 0x00 = bits [127:96]
aes_pt  out  128  plaintext; word 0x10 = bits [127:96]
aes_start  out  1  one-cycle start pulse to the core
aes_done  in  1  one-cycle done pulse from the core
aes_ct  in  128  ciphertext, valid in the aes_done cycle

Behaviour:
- Register map (word-aligned; addr[1:0] ignored):
  - 0x00-0x0C KEY0-3 RW.
  - 0x10-0x1C PT0-3 RW.
  - 0x20 CTRL: bit0 START, write-1 pulses; reads 0.
  - 0x24 STATUS RO: bit0 BUSY, bit1 DONE.
  - 0x28-0x34 CT0-3 RO.
  - 0x38-0x3C unmapped.
- Reset: all ready/valid outputs 0, bresp/rresp 0, rdata 0, all registers 0, aes_start 0, BUSY 0, DONE 0.
- Write channel FSM, states W_IDLE -> W_RESP -> W_IDLE:
  - In W_IDLE, awready and wready are both asserted for one cycle only when awvalid && wvalid. AW and W are accepted together; one arriving alone waits.
  - On acceptance: register is updated per wstrb byte lanes, bvalid=1 next cycle.
  - bvalid holds until bready. No new AW/W is accepted while bvalid is high.
  - bresp OKAY (2'b00) for RW/CTRL addresses. SLVERR (2'b10) for RO or unmapped addresses; register contents are unchanged.
- Read channel FSM, states R_IDLE -> R_DATA -> R_IDLE:
  - arready pulses one cycle when arvalid in R_IDLE.
  - rdata/rresp are registered; rvalid=1 the cycle after acceptance and held stable until rready.
  - rresp OKAY for mapped addresses, SLVERR with rdata 0 for unmapped.
- Start control:
  - Write to CTRL with wdata[0]=1, wstrb[0]=1 and BUSY=0: aes_start=1 for exactly one cycle, the cycle after W acceptance. BUSY set and DONE cleared that same cycle.
  - START while BUSY=1 is ignored; bresp is still OKAY.
  - KEY/PT writes while BUSY=1 return SLVERR and leave the registers unchanged, so aes_key/aes_pt are stable for the whole operation.
- Completion: aes_done while BUSY=1 captures aes_ct into CT0-3 and sets BUSY=0, DONE=1 the next cycle. DONE stays sticky until the next accepted START. aes_done while BUSY=0 is ignored.
- Simultaneous events: a read of STATUS/CT in the same cycle as aes_done returns the pre-update value. The read and write FSMs run independently and may complete in the same cycle.
- Reset mid-operation: all state returns to reset values immediately. An in-flight response is dropped, and a later aes_done is ignored.

Test Plan:
- Reset then read 0x00-0x34 -> every rdata 0, rresp OKAY; 0x38 -> SLVERR, rdata 0.
- Write KEY0-3 = 0x00000001..0x00000004, read back -> same values in order; aes_key = 0x00000001_00000002_00000003_00000004.
- Write KEY0 = 0xFFFFFFFF with wstrb 4'b0101 after reset -> readback 0x00FF00FF.
- Load FIPS-197 key 000102..0f and pt 00112233..ff, write CTRL=1, then:
  - aes_start high for exactly 1 cycle; STATUS=0x1 during the operation.
  - Model asserts aes_done with ct 69c4e0d8_6a7b0430_d8cdb780_70b4c55a -> STATUS=0x2, CT0=0x69c4e0d8, CT3=0x70b4c55a.
- While BUSY: write PT0 -> SLVERR, PT0 unchanged; write CTRL=1 -> OKAY with no second aes_start. Write to CT1 -> SLVERR.
- Handshake stress: AW 3 cycles before W, then bready held low for 5 cycles -> a single write; bvalid stable throughout; no awready until the B handshake completes. Assert reset while BUSY -> STATUS=0, and a later aes_done leaves CT=0.
